// File: rtl/memory_stage.sv
// Purpose: execute->writeback memory stage; LDW/LDB/STW/STB on word-organised data memory plus LEDR/HEX/SW I/O window.
// Latency: one falling edge for non-memory ops; MEM_LATENCY edges for loads/stores (bubbles emitted while waiting).
// Backpressure: O_MemStallSignal holds fetch/decode/execute while a multi-cycle access is outstanding.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 16
`endif
`ifndef IR_WIDTH
`define IR_WIDTH 32
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef VREG_WIDTH
`define VREG_WIDTH 64
`endif
`ifndef VREG_ID_WIDTH
`define VREG_ID_WIDTH 6
`endif
`ifndef OP_LDB
`define OP_LDB 8'h41
`endif
`ifndef OP_LDW
`define OP_LDW 8'h42
`endif
`ifndef OP_STB
`define OP_STB 8'h43
`endif
`ifndef OP_STW
`define OP_STW 8'h44
`endif

module memory_stage #(
    parameter int          DMEM_DEPTH  = 1024,
    parameter int          MEM_LATENCY = 1,
    parameter logic [15:0] ADDR_LEDR   = 16'hF000,
    parameter logic [15:0] ADDR_HEX    = 16'hF002,
    parameter logic [15:0] ADDR_SW     = 16'hF004
) (
    input  logic                          I_CLOCK,
    input  logic                          I_RESET,
    input  logic                          I_LOCK,
    input  logic                          I_EX_Valid,
    input  logic [`OPCODE_WIDTH-1:0]      I_Opcode,
    input  logic [`PC_WIDTH-1:0]          I_PC,
    input  logic [`PC_WIDTH-1:0]          I_R15PC,
    input  logic [`IR_WIDTH-1:0]          I_IR,
    input  logic [`REG_WIDTH-1:0]         I_MARValue,
    input  logic [`REG_WIDTH-1:0]         I_MDRValue,
    input  logic [`REG_WIDTH-1:0]         I_DestValue,
    input  logic [3:0]                    I_DestRegIdx,
    input  logic                          I_RegWEn,
    input  logic                          I_CCWEn,
    input  logic                          I_VRegWEn,
    input  logic [2:0]                    I_CCValue,
    input  logic [`VREG_WIDTH-1:0]        I_VecDestValue,
    input  logic [`VREG_ID_WIDTH-1:0]     I_DestVRegIdx,
    input  logic [9:0]                    I_SW,
    output logic                          O_LOCK,
    output logic                          O_MEM_Valid,
    output logic [`OPCODE_WIDTH-1:0]      O_Opcode,
    output logic [`PC_WIDTH-1:0]          O_PC,
    output logic [`PC_WIDTH-1:0]          O_R15PC,
    output logic [`IR_WIDTH-1:0]          O_IR,
    output logic [`REG_WIDTH-1:0]         O_DestValue,
    output logic [3:0]                    O_DestRegIdx,
    output logic [2:0]                    O_CCValue,
    output logic [`VREG_WIDTH-1:0]        O_VecDestValue,
    output logic [`VREG_ID_WIDTH-1:0]     O_DestVRegIdx,
    output logic                          O_RegWEn,
    output logic                          O_CCWEn,
    output logic                          O_VRegWEn,
    output logic                          O_RegWEn_Signal,
    output logic                          O_CCWEn_Signal,
    output logic                          O_VRegWEn_Signal,
    output logic                          O_MemStallSignal,
    output logic [9:0]                    O_LEDR,
    output logic [15:0]                   O_HEX
);

    localparam int             AW       = $clog2(DMEM_DEPTH);
    localparam int             CW       = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(MEM_LATENCY - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_dmem [DMEM_DEPTH];

    logic            w_in_vld, w_is_load, w_is_store, w_memop, w_fire;
    logic [14:0]     w_idx;
    logic            w_in_range, w_hit_ledr, w_hit_hex, w_hit_sw, w_mmio;
    logic [15:0]     w_mem_word, w_raw, w_load_val, w_st_word;
    logic [7:0]      w_byte;
    logic [2:0]      w_load_cc;
    logic            w_mem_we;

    assign w_in_vld   = I_LOCK & I_EX_Valid;
    assign w_is_load  = (I_Opcode == `OP_LDW) | (I_Opcode == `OP_LDB);
    assign w_is_store = (I_Opcode == `OP_STW) | (I_Opcode == `OP_STB);
    assign w_memop    = w_in_vld & (w_is_load | w_is_store);

    // The access happens on the last edge of its latency window; with latency 1 that is the issue edge.
    assign w_fire = w_memop & (((r_state == S_IDLE) & (MEM_LATENCY == 1)) |
                               ((r_state == S_WAIT) & (r_cnt == CNT_ONE)));

    assign O_MemStallSignal = ((r_state == S_IDLE) & w_memop & (MEM_LATENCY > 1)) |
                              ((r_state == S_WAIT) & (r_cnt != CNT_ONE));

    assign O_RegWEn_Signal  = w_in_vld & I_RegWEn;
    assign O_CCWEn_Signal   = w_in_vld & I_CCWEn;
    assign O_VRegWEn_Signal = w_in_vld & I_VRegWEn;

    // Address decode: I/O window takes priority over the memory range.
    assign w_idx      = I_MARValue[15:1];
    assign w_in_range = ((w_idx >> AW) == '0);
    assign w_hit_ledr = (I_MARValue == ADDR_LEDR);
    assign w_hit_hex  = (I_MARValue == ADDR_HEX);
    assign w_hit_sw   = (I_MARValue == ADDR_SW);
    assign w_mmio     = w_hit_ledr | w_hit_hex | w_hit_sw;
    assign w_mem_word = r_dmem[w_idx[AW-1:0]];

    // Load data selection, byte extraction/sign extension and NZP condition codes.
    always_comb begin
        w_raw = '0;
        if (w_hit_sw)
            w_raw = {6'b0, I_SW};
        else if (!w_mmio && w_in_range)
            w_raw = w_mem_word;
        w_byte     = I_MARValue[0] ? w_raw[15:8] : w_raw[7:0];
        w_load_val = (I_Opcode == `OP_LDB) ? {{8{w_byte[7]}}, w_byte} : w_raw;
        if (w_load_val[15])
            w_load_cc = 3'b100;
        else if (w_load_val == 16'h0000)
            w_load_cc = 3'b010;
        else
            w_load_cc = 3'b001;
    end

    // STB merges the new byte into the lane picked by MAR[0], keeping the other lane.
    assign w_st_word = (I_Opcode == `OP_STB) ?
                       (I_MARValue[0] ? {I_MDRValue[7:0], w_mem_word[7:0]}
                                      : {w_mem_word[15:8], I_MDRValue[7:0]}) :
                       I_MDRValue;
    // Reset on the firing edge aborts the store.
    assign w_mem_we  = w_fire & w_is_store & ~w_mmio & w_in_range & ~I_RESET;

    // Data memory write port; contents survive reset.
    always_ff @(negedge I_CLOCK) begin
        if (w_mem_we)
            r_dmem[w_idx[AW-1:0]] <= w_st_word;
    end

    // Latency FSM: count down the wait window of a multi-cycle access.
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_memop && (MEM_LATENCY > 1)) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_INIT;
                    end
                end
                default: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE)
                        r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Writeback bundle register: pass-through, load result, or bubble.
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            O_LOCK         <= 1'b0;
            O_MEM_Valid    <= 1'b0;
            O_Opcode       <= '0;
            O_PC           <= '0;
            O_R15PC        <= '0;
            O_IR           <= '0;
            O_DestValue    <= '0;
            O_DestRegIdx   <= '0;
            O_CCValue      <= '0;
            O_VecDestValue <= '0;
            O_DestVRegIdx  <= '0;
            O_RegWEn       <= 1'b0;
            O_CCWEn        <= 1'b0;
            O_VRegWEn      <= 1'b0;
        end else begin
            O_LOCK         <= I_LOCK;
            O_Opcode       <= I_Opcode;
            O_PC           <= I_PC;
            O_R15PC        <= I_R15PC;
            O_IR           <= I_IR;
            O_DestRegIdx   <= I_DestRegIdx;
            O_VecDestValue <= I_VecDestValue;
            O_DestVRegIdx  <= I_DestVRegIdx;
            if (w_memop) begin
                O_MEM_Valid <= w_fire;
                O_VRegWEn   <= 1'b0;
                if (w_fire && w_is_load) begin
                    O_DestValue <= w_load_val;
                    O_CCValue   <= w_load_cc;
                    O_RegWEn    <= 1'b1;
                    O_CCWEn     <= 1'b1;
                end else begin
                    O_DestValue <= I_DestValue;
                    O_CCValue   <= I_CCValue;
                    O_RegWEn    <= 1'b0;
                    O_CCWEn     <= 1'b0;
                end
            end else begin
                O_MEM_Valid <= w_in_vld;
                O_DestValue <= I_DestValue;
                O_CCValue   <= I_CCValue;
                O_RegWEn    <= w_in_vld & I_RegWEn;
                O_CCWEn     <= w_in_vld & I_CCWEn;
                O_VRegWEn   <= w_in_vld & I_VRegWEn;
            end
        end
    end

    // I/O output registers, updated only by stores to their addresses.
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            O_LEDR <= '0;
            O_HEX  <= '0;
        end else if (w_fire && w_is_store) begin
            if (w_hit_ledr)
                O_LEDR <= I_MDRValue[9:0];
            if (w_hit_hex)
                O_HEX <= I_MDRValue;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: three instances with latency 1, 3 and 4 share stimulus;
// only the selected instance sees a valid bundle, the others see bubbles.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 16
`endif
`ifndef IR_WIDTH
`define IR_WIDTH 32
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef VREG_WIDTH
`define VREG_WIDTH 64
`endif
`ifndef VREG_ID_WIDTH
`define VREG_ID_WIDTH 6
`endif
`ifndef OP_LDB
`define OP_LDB 8'h41
`endif
`ifndef OP_LDW
`define OP_LDW 8'h42
`endif
`ifndef OP_STB
`define OP_STB 8'h43
`endif
`ifndef OP_STW
`define OP_STW 8'h44
`endif

module tb_memory_stage;

    localparam logic [7:0] OP_ADD = 8'h01;

    logic clk;
    logic rst;
    logic lock;
    logic ex_valid;
    int   sel;
    logic [`OPCODE_WIDTH-1:0]  opc;
    logic [`PC_WIDTH-1:0]      pc, r15;
    logic [`IR_WIDTH-1:0]      ir;
    logic [`REG_WIDTH-1:0]     mar, mdr, dval;
    logic [3:0]                didx;
    logic                      rwe, cwe, vwe;
    logic [2:0]                ccv;
    logic [`VREG_WIDTH-1:0]    vdval;
    logic [`VREG_ID_WIDTH-1:0] vdidx;
    logic [9:0]                sw;

    logic                      o_lock [3];
    logic                      o_vld [3];
    logic [`OPCODE_WIDTH-1:0]  o_opc [3];
    logic [`PC_WIDTH-1:0]      o_pc [3];
    logic [`PC_WIDTH-1:0]      o_r15 [3];
    logic [`IR_WIDTH-1:0]      o_ir [3];
    logic [`REG_WIDTH-1:0]     o_dest [3];
    logic [3:0]                o_didx [3];
    logic [2:0]                o_cc [3];
    logic [`VREG_WIDTH-1:0]    o_vdest [3];
    logic [`VREG_ID_WIDTH-1:0] o_vidx [3];
    logic                      o_rwe [3], o_cwe [3], o_vwe [3];
    logic                      o_rsig [3], o_csig [3], o_vsig [3];
    logic                      o_stall [3];
    logic [9:0]                o_ledr [3];
    logic [15:0]               o_hex [3];

    int n_checks = 0;
    int n_err    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        memory_stage #(.MEM_LATENCY(LAT)) u_dut (
            .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock),
            .I_EX_Valid(ex_valid && (sel == g)),
            .I_Opcode(opc), .I_PC(pc), .I_R15PC(r15), .I_IR(ir),
            .I_MARValue(mar), .I_MDRValue(mdr), .I_DestValue(dval),
            .I_DestRegIdx(didx), .I_RegWEn(rwe), .I_CCWEn(cwe), .I_VRegWEn(vwe),
            .I_CCValue(ccv), .I_VecDestValue(vdval), .I_DestVRegIdx(vdidx), .I_SW(sw),
            .O_LOCK(o_lock[g]), .O_MEM_Valid(o_vld[g]), .O_Opcode(o_opc[g]),
            .O_PC(o_pc[g]), .O_R15PC(o_r15[g]), .O_IR(o_ir[g]),
            .O_DestValue(o_dest[g]), .O_DestRegIdx(o_didx[g]), .O_CCValue(o_cc[g]),
            .O_VecDestValue(o_vdest[g]), .O_DestVRegIdx(o_vidx[g]),
            .O_RegWEn(o_rwe[g]), .O_CCWEn(o_cwe[g]), .O_VRegWEn(o_vwe[g]),
            .O_RegWEn_Signal(o_rsig[g]), .O_CCWEn_Signal(o_csig[g]),
            .O_VRegWEn_Signal(o_vsig[g]), .O_MemStallSignal(o_stall[g]),
            .O_LEDR(o_ledr[g]), .O_HEX(o_hex[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the active (falling) edge and settle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] dv, input logic rw, input logic cw, input logic [2:0] cc);
        ex_valid = 1'b1;
        opc = op; mar = a; mdr = d; dval = dv; rwe = rw; cwe = cw; ccv = cc;
    endtask

    initial begin
        rst = 1'b1; lock = 1'b1; ex_valid = 1'b0; sel = 0;
        opc = '0; pc = 16'h0100; r15 = 16'h0102; ir = 32'h1234_5678;
        mar = '0; mdr = '0; dval = '0; didx = 4'd0; rwe = 1'b0; cwe = 1'b0; vwe = 1'b0;
        ccv = 3'b000; vdval = 64'h0; vdidx = '0; sw = 10'h000;
        tick();
        tick();
        chk("rst_vld", 64'(o_vld[0]), 64'd0);
        chk("rst_dest", 64'(o_dest[0]), 64'd0);
        chk("rst_pc", 64'(o_pc[0]), 64'd0);
        chk("rst_ledr", 64'(o_ledr[0]), 64'd0);
        chk("rst_stall3", 64'(o_stall[1]), 64'd0);
        rst = 1'b0;

        // Latency 1: word store then load back.
        drive(`OP_STW, 16'h0010, 16'hBEEF, 16'h0, 1'b0, 1'b0, 3'b000);
        #1 chk("stw_nostall", 64'(o_stall[0]), 64'd0);
        tick();
        chk("stw_vld", 64'(o_vld[0]), 64'd1);
        chk("stw_rwe", 64'(o_rwe[0]), 64'd0);
        drive(`OP_LDW, 16'h0010, 16'h0, 16'h0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("ldw_dest", 64'(o_dest[0]), 64'hBEEF);
        chk("ldw_rwe", 64'(o_rwe[0]), 64'd1);
        chk("ldw_cwe", 64'(o_cwe[0]), 64'd1);
        chk("ldw_cc", 64'(o_cc[0]), 64'b100);
        chk("ldw_vld", 64'(o_vld[0]), 64'd1);

        // Byte store / byte load lanes.
        drive(`OP_STW, 16'h0010, 16'h1234, 16'h0, 1'b0, 1'b0, 3'b000);
        tick();
        drive(`OP_STB, 16'h0011, 16'h00AB, 16'h0, 1'b0, 1'b0, 3'b000);
        tick();
        drive(`OP_LDB, 16'h0011, 16'h0, 16'h0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("ldb_hi", 64'(o_dest[0]), 64'hFFAB);
        chk("ldb_hi_cc", 64'(o_cc[0]), 64'b100);
        drive(`OP_LDW, 16'h0010, 16'h0, 16'h0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("ldw_merged", 64'(o_dest[0]), 64'hAB34);
        drive(`OP_LDB, 16'h0010, 16'h0, 16'h0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("ldb_lo", 64'(o_dest[0]), 64'h0034);
        chk("ldb_lo_cc", 64'(o_cc[0]), 64'b001);

        // Non-memory pass-through and hazard-check signals.
        didx = 4'd3;
        drive(OP_ADD, 16'h0, 16'h0, 16'h5555, 1'b1, 1'b1, 3'b001);
        #1 chk("rsig_on", 64'(o_rsig[0]), 64'd1);
        lock = 1'b0;
        #1 chk("rsig_locked", 64'(o_rsig[0]), 64'd0);
        lock = 1'b1;
        tick();
        chk("add_dest", 64'(o_dest[0]), 64'h5555);
        chk("add_cc", 64'(o_cc[0]), 64'b001);
        chk("add_rwe", 64'(o_rwe[0]), 64'd1);
        chk("add_didx", 64'(o_didx[0]), 64'd3);

        // Bubble: an invalid store must not write.
        drive(`OP_STW, 16'h0010, 16'h0000, 16'h0, 1'b1, 1'b1, 3'b000);
        ex_valid = 1'b0;
        tick();
        chk("bub_vld", 64'(o_vld[0]), 64'd0);
        chk("bub_rwe", 64'(o_rwe[0]), 64'd0);
        drive(`OP_LDW, 16'h0010, 16'h0, 16'h0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("bub_nowrite", 64'(o_dest[0]), 64'hAB34);

        // I/O window.
        drive(`OP_STW, 16'hF000, 16'h03FF, 16'h0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("ledr", 64'(o_ledr[0]), 64'h3FF);
        drive(`OP_STW, 16'hF002, 16'hCAFE, 16'h0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("hex", 64'(o_hex[0]), 64'hCAFE);
        chk("ledr_hold", 64'(o_ledr[0]), 64'h3FF);
        sw = 10'h155;
        drive(`OP_LDW, 16'hF004, 16'h0, 16'h0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("sw_load", 64'(o_dest[0]), 64'h0155);
        chk("sw_cc", 64'(o_cc[0]), 64'b001);
        drive(`OP_LDW, 16'hF000, 16'h0, 16'hFFFF, 1'b0, 1'b0, 3'b000);
        tick();
        chk("ledr_load0", 64'(o_dest[0]), 64'h0000);
        chk("ledr_load_cc", 64'(o_cc[0]), 64'b010);

        // Out-of-range addresses must neither read nor alias.
        drive(`OP_STW, 16'h0000, 16'h1111, 16'h0, 1'b0, 1'b0, 3'b000);
        tick();
        drive(`OP_STW, 16'h1000, 16'h7777, 16'h0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("oor_st_vld", 64'(o_vld[0]), 64'd1);
        drive(`OP_LDW, 16'h1000, 16'h0, 16'h0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("oor_ld", 64'(o_dest[0]), 64'h0000);
        chk("oor_cc", 64'(o_cc[0]), 64'b010);
        chk("oor_vld", 64'(o_vld[0]), 64'd1);
        drive(`OP_LDW, 16'h0000, 16'h0, 16'h0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("oor_noalias", 64'(o_dest[0]), 64'h1111);

        // Latency 3.
        ex_valid = 1'b0;
        sel = 1;
        drive(`OP_STW, 16'h0020, 16'h8001, 16'h0, 1'b0, 1'b0, 3'b000);
        repeat (3) tick();
        chk("l3_st_vld", 64'(o_vld[1]), 64'd1);
        drive(`OP_LDW, 16'h0020, 16'h0, 16'h0, 1'b0, 1'b0, 3'b000);
        #1 chk("l3_stall_issue", 64'(o_stall[1]), 64'd1);
        tick();
        chk("l3_bub1", 64'(o_vld[1]), 64'd0);
        chk("l3_stall_e1", 64'(o_stall[1]), 64'd1);
        tick();
        chk("l3_bub2", 64'(o_vld[1]), 64'd0);
        chk("l3_stall_e2", 64'(o_stall[1]), 64'd0);
        tick();
        chk("l3_vld", 64'(o_vld[1]), 64'd1);
        chk("l3_dest", 64'(o_dest[1]), 64'h8001);
        chk("l3_cc", 64'(o_cc[1]), 64'b100);
        drive(OP_ADD, 16'h0, 16'h0, 16'h0042, 1'b1, 1'b1, 3'b001);
        #1 chk("l3_add_nostall", 64'(o_stall[1]), 64'd0);
        tick();
        chk("l3_add_dest", 64'(o_dest[1]), 64'h0042);
        chk("l3_add_cc", 64'(o_cc[1]), 64'b001);

        // Latency 4: reset on the firing edge aborts the store.
        ex_valid = 1'b0;
        sel = 2;
        drive(`OP_STW, 16'h0030, 16'h5A5A, 16'h0, 1'b0, 1'b0, 3'b000);
        repeat (3) tick();
        chk("l4_bub3", 64'(o_vld[2]), 64'd0);
        tick();
        chk("l4_st_vld", 64'(o_vld[2]), 64'd1);
        drive(`OP_STW, 16'h0030, 16'hFFFF, 16'h0, 1'b0, 1'b0, 3'b000);
        repeat (3) tick();
        chk("l4_stall_last", 64'(o_stall[2]), 64'd0);
        rst = 1'b1;
        tick();
        chk("l4_rst_vld", 64'(o_vld[2]), 64'd0);
        chk("l4_rst_dest", 64'(o_dest[2]), 64'd0);
        chk("l4_rst_opc", 64'(o_opc[2]), 64'd0);
        chk("l4_rst_ledr", 64'(o_ledr[0]), 64'd0);
        chk("l4_rst_hex", 64'(o_hex[0]), 64'd0);
        ex_valid = 1'b0;
        #1 chk("l4_rst_stall", 64'(o_stall[2]), 64'd0);
        rst = 1'b0;
        drive(`OP_LDW, 16'h0030, 16'h0, 16'h0, 1'b0, 1'b0, 3'b000);
        repeat (4) tick();
        chk("l4_aborted", 64'(o_dest[2]), 64'h5A5A);
        chk("l4_ld_vld", 64'(o_vld[2]), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
